im_port_arbiter: RTL and testbench

//  Shares the single-port instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).

---
 rtl/im_port_arbiter_if.sv | 52 +++++
 rtl/im_port_arbiter.sv | 132 +++++++++++++
 tb/tb_im_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : im_port_arbiter_if
// Purpose  : Bundles the fetch port, loader port and IM array lines that meet
//            at the instruction-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface im_port_arbiter_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH_W = 10
) ();
  // fetch requester
  logic               f_req;
  logic [AW-1:0]      f_addr;
  logic               f_gnt;
  logic               f_rvalid;
  logic [DW-1:0]      f_rdata;
  logic               f_err;
  // loader / debug requester
  logic               ld_req;
  logic               ld_we;
  logic               ld_lock;
  logic [AW-1:0]      ld_addr;
  logic [DW-1:0]      ld_wdata;
  logic               ld_gnt;
  logic               ld_rvalid;
  logic [DW-1:0]      ld_rdata;
  logic               ld_err;
  // IM array
  logic [DEPTH_W-1:0] im_addr;
  logic               im_we;
  logic [DW-1:0]      im_wdata;
  logic [DW-1:0]      im_rdata;

  // arbiter side
  modport slave (
    input  f_req, f_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, im_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output ld_gnt, ld_rvalid, ld_rdata, ld_err,
    output im_addr, im_we, im_wdata
  );

  // requesters and IM array side
  modport master (
    output f_req, f_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, im_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
    input  im_addr, im_we, im_wdata
  );
endinterface
`default_nettype wire

// File: rtl/im_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : im_port_arbiter
// Purpose  : Shares the single-port instruction memory between the fetch
//            stage (read-only) and the loader/debug port (read/write).
//            Grants are combinational, responses return one cycle later.
//            Optional macro IM_ARB_STARVE_EN builds the loader anti-starvation
//            counter; without it fetch has strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module im_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int DEPTH_W      = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  im_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LOAD   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t r_state;
  logic   r_f_pend;
  logic   r_f_err;
  logic   r_ld_pend;
  logic   r_ld_err;
  logic   w_loader_turn;
  logic   w_f_gnt;
  logic   w_ld_gnt;
  logic   w_f_aligned;
  logic   w_ld_aligned;
  logic   w_unused_addr_bits;

  assign w_f_aligned  = (bus.f_addr[1:0] == 2'b00);
  assign w_ld_aligned = (bus.ld_addr[1:0] == 2'b00);

  // Only the word-index bits reach the array; the rest are don't-care.
  assign w_unused_addr_bits = ^{bus.f_addr[AW-1:DEPTH_W+2], bus.ld_addr[AW-1:DEPTH_W+2]};

`ifdef IM_ARB_STARVE_EN
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_loader_turn = (r_starve_cnt == c_starve_limit);

  // Count fetch wins taken while the loader waits; any loader grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_ld_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_f_gnt && bus.ld_req && (r_starve_cnt != c_starve_limit)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  // Strict fetch priority: the limit has no meaning in this build.
  localparam int c_unused_starve_limit = STARVE_LIMIT;
  assign w_loader_turn = 1'b0;
`endif

  // Grant selection: locked loader owns the port, else fetch first unless starved.
  always_comb begin
    w_f_gnt  = 1'b0;
    w_ld_gnt = 1'b0;
    if (!rst) begin
      if (r_state == LOCKED) begin
        w_ld_gnt = bus.ld_req;
      end else begin
        w_f_gnt  = bus.f_req  && (!bus.ld_req || !w_loader_turn);
        w_ld_gnt = bus.ld_req && (!bus.f_req  ||  w_loader_turn);
      end
    end
  end

  assign bus.f_gnt    = w_f_gnt;
  assign bus.ld_gnt   = w_ld_gnt;
  assign bus.im_addr  = w_ld_gnt ? bus.ld_addr[DEPTH_W+1:2] : bus.f_addr[DEPTH_W+1:2];
  assign bus.im_we    = w_ld_gnt && bus.ld_we && w_ld_aligned;
  assign bus.im_wdata = bus.ld_wdata;

  assign bus.f_rvalid  = r_f_pend;
  assign bus.f_err     = r_f_err;
  assign bus.f_rdata   = r_f_pend ? bus.im_rdata : '0;
  assign bus.ld_rvalid = r_ld_pend;
  assign bus.ld_err    = r_ld_err;
  assign bus.ld_rdata  = r_ld_pend ? bus.im_rdata : '0;

  // Ownership state plus the registered response owner for next-cycle routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_f_pend  <= 1'b0;
      r_f_err   <= 1'b0;
      r_ld_pend <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_f_pend  <= w_f_gnt;
      r_f_err   <= w_f_gnt && !w_f_aligned;
      r_ld_pend <= w_ld_gnt;
      r_ld_err  <= w_ld_gnt && !w_ld_aligned;
      case (r_state)
        LOCKED: begin
          // Release only on a quiet cycle, so no loader access is left in flight.
          if (!bus.ld_lock && !w_ld_gnt) begin
            r_state <= IDLE;
          end
        end
        default: begin
          if (w_ld_gnt && bus.ld_lock) begin
            r_state <= LOCKED;
          end else if (w_ld_gnt) begin
            r_state <= LOAD;
          end else if (w_f_gnt) begin
            r_state <= FETCH;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_port_arbiter
// Purpose  : Self-checking bench for im_port_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_port_arbiter;
  localparam int LIMIT = 4;
`ifdef IM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  im_port_arbiter_if #(.AW(32), .DW(32), .DEPTH_W(10)) bus ();

  im_port_arbiter #(.AW(32), .DW(32), .DEPTH_W(10), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // Write-first, registered-read IM array; contents seeded on the first edge.
  logic [31:0] mem [1024];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus.im_we) mem[bus.im_addr] <= bus.im_wdata;
      bus.im_rdata <= bus.im_we ? bus.im_wdata : mem[bus.im_addr];
    end
  end

  // Reference model: expected memory image, ownership and pending responses.
  logic [31:0] gold [1024];
  bit m_locked;
  int m_wins;
  bit m_f_v, m_f_err, m_ld_v, m_ld_err;
  logic [31:0] m_f_data, m_ld_data;
  bit e_f_gnt, e_ld_gnt;
  logic [112:0] exp_vec, obs_vec;
  logic o_f_gnt, o_ld_gnt, o_im_we, o_f_rvalid, o_ld_rvalid, o_ld_err;
  logic [9:0] o_im_addr;
  logic [31:0] o_f_rdata, o_ld_rdata;

  task automatic model_reset();
    m_locked = 0; m_wins = 0;
    m_f_v = 0; m_f_err = 0; m_ld_v = 0; m_ld_err = 0;
    m_f_data = '0; m_ld_data = '0;
    e_f_gnt = 0; e_ld_gnt = 0;
  endtask

  task automatic set_idle();
    bus.f_req = 0; bus.f_addr = '0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_lock = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
  endtask

  // One clock: predict from the model, capture DUT outputs mid-cycle, advance model.
  task automatic run_cycle();
    logic [9:0] fi, li;
    bit turn, e_we;
    @(negedge clk);
    fi = bus.f_addr[11:2];
    li = bus.ld_addr[11:2];
    turn = STARVE_EN && (m_wins == LIMIT);
    if (m_locked) begin
      e_f_gnt = 0; e_ld_gnt = bus.ld_req;
    end else begin
      e_f_gnt  = bus.f_req  && (!bus.ld_req || !turn);
      e_ld_gnt = bus.ld_req && (!bus.f_req  ||  turn);
    end
    e_we = e_ld_gnt && bus.ld_we && (bus.ld_addr[1:0] == 2'b00);
    exp_vec = {e_f_gnt, e_ld_gnt, e_we, (e_ld_gnt ? li : fi),
               m_f_v, m_f_err, (m_f_v ? m_f_data : 32'h0),
               m_ld_v, m_ld_err, (m_ld_v ? m_ld_data : 32'h0), bus.ld_wdata};
    obs_vec = {bus.f_gnt, bus.ld_gnt, bus.im_we, bus.im_addr,
               bus.f_rvalid, bus.f_err, (m_f_v ? bus.f_rdata : 32'h0),
               bus.ld_rvalid, bus.ld_err, (m_ld_v ? bus.ld_rdata : 32'h0), bus.im_wdata};
    o_f_gnt = bus.f_gnt; o_ld_gnt = bus.ld_gnt; o_im_we = bus.im_we; o_im_addr = bus.im_addr;
    o_f_rvalid = bus.f_rvalid; o_f_rdata = bus.f_rdata;
    o_ld_rvalid = bus.ld_rvalid; o_ld_err = bus.ld_err; o_ld_rdata = bus.ld_rdata;
    if (e_we) gold[li] = bus.ld_wdata;
    m_f_v  = e_f_gnt;  m_f_err  = e_f_gnt  && (bus.f_addr[1:0]  != 2'b00); m_f_data  = gold[fi];
    m_ld_v = e_ld_gnt; m_ld_err = e_ld_gnt && (bus.ld_addr[1:0] != 2'b00); m_ld_data = gold[li];
    if (e_ld_gnt) m_wins = 0;
    else if (e_f_gnt && bus.ld_req && m_wins < LIMIT) m_wins++;
    if (e_ld_gnt && bus.ld_lock) m_locked = 1;
    else if (m_locked && !bus.ld_lock && !e_ld_gnt) m_locked = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.f_gnt, bus.ld_gnt, bus.f_rvalid, bus.f_err, bus.ld_rvalid, bus.ld_err,
         bus.im_we, bus.im_addr, bus.im_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got gnt=%b/%b rv=%b/%b we=%b addr=%h, want all 0",
        bus.f_gnt, bus.ld_gnt, bus.f_rvalid, bus.ld_rvalid, bus.im_we, bus.im_addr);
    end
    rst = 0; model_reset();
    @(posedge clk); #1;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle: got %h want %h", obs_vec, exp_vec); end
  endtask

  task automatic test_fetch_basic();
    bus.f_req = 1; bus.f_addr = 32'h10;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL fetch_grant_vec: got %h want %h", obs_vec, exp_vec); end
    checks++; if (o_f_gnt !== 1'b1 || o_im_addr !== 10'd4) begin errors++; $display("FAIL fetch_grant: got gnt=%b addr=%0d want gnt=1 addr=4", o_f_gnt, o_im_addr); end
    set_idle();
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL fetch_resp_vec: got %h want %h", obs_vec, exp_vec); end
    checks++; if (o_f_rvalid !== 1'b1 || o_f_rdata !== init_word(4)) begin errors++; $display("FAIL fetch_resp: got rv=%b data=%h want rv=1 data=%h", o_f_rvalid, o_f_rdata, init_word(4)); end
  endtask

  task automatic test_starvation();
    bit [9:0] ld_mask, want;
    ld_mask = '0;
    bus.f_req = 1; bus.f_addr = 32'h40;
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL starve_vec cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      ld_mask[i] = o_ld_gnt;
    end
    want = STARVE_EN ? 10'b10_0001_0000 : 10'b00_0000_0000;
    checks++; if (ld_mask !== want) begin errors++; $display("FAIL starve_pattern: got ld grants %b want %b", ld_mask, want); end
    set_idle();
    repeat (2) begin
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL starve_drain: got %h want %h", obs_vec, exp_vec); end
    end
  endtask

  task automatic test_raw();
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'hDEADBEEF;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL raw_write: got %h want %h", obs_vec, exp_vec); end
    set_idle(); bus.f_req = 1; bus.f_addr = 32'h20;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL raw_fetch: got %h want %h", obs_vec, exp_vec); end
    set_idle();
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL raw_resp_vec: got %h want %h", obs_vec, exp_vec); end
    checks++; if (o_f_rvalid !== 1'b1 || o_f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data: got rv=%b data=%h want rv=1 data=deadbeef", o_f_rvalid, o_f_rdata); end
  endtask

  task automatic test_lock();
    int f_gnts, ld_rv;
    bit f_after;
    logic [31:0] d1;
    f_gnts = 0; ld_rv = 0; f_after = 0; d1 = '0;
    set_idle();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        bus.ld_req = 1; bus.ld_lock = 1; bus.ld_we = 1;
        bus.ld_addr = 32'h100 + 32'(4 * c); bus.ld_wdata = $urandom;
        if (c == 1) d1 = bus.ld_wdata;
      end else begin
        bus.ld_req = 0; bus.ld_lock = 0; bus.ld_we = 0;
      end
      if (c >= 1) begin bus.f_req = 1; bus.f_addr = 32'h104; end
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL lock_vec cyc%0d: got %h want %h", c, obs_vec, exp_vec); end
      if (c >= 1 && c <= 3) f_gnts += int'(o_f_gnt);
      ld_rv += int'(o_ld_rvalid);
      if (c == 4) f_after = o_f_gnt;
    end
    checks++; if (f_gnts != 0) begin errors++; $display("FAIL lock_fetch_blocked: got %0d fetch grants want 0", f_gnts); end
    checks++; if (ld_rv != 3) begin errors++; $display("FAIL lock_responses: got %0d ld_rvalid want 3", ld_rv); end
    checks++; if (f_after !== 1'b1) begin errors++; $display("FAIL lock_release: got f_gnt=%b want 1", f_after); end
    set_idle();
    run_cycle();
    checks++; if (o_f_rvalid !== 1'b1 || o_f_rdata !== d1) begin errors++; $display("FAIL lock_readback: got rv=%b data=%h want rv=1 data=%h", o_f_rvalid, o_f_rdata, d1); end
  endtask

  task automatic test_misaligned();
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 32'h22; bus.ld_wdata = 32'h12345678;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL misal_vec: got %h want %h", obs_vec, exp_vec); end
    checks++; if (o_im_we !== 1'b0) begin errors++; $display("FAIL misal_we: got im_we=%b want 0", o_im_we); end
    bus.ld_we = 0; bus.ld_addr = 32'h20; bus.ld_wdata = '0;
    run_cycle();
    checks++; if (o_ld_rvalid !== 1'b1 || o_ld_err !== 1'b1) begin errors++; $display("FAIL misal_err: got rv=%b err=%b want 1/1", o_ld_rvalid, o_ld_err); end
    set_idle();
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL misal_read_vec: got %h want %h", obs_vec, exp_vec); end
    checks++; if (o_ld_err !== 1'b0 || o_ld_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL misal_unchanged: got err=%b data=%h want 0/deadbeef", o_ld_err, o_ld_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!bus.f_req || e_f_gnt) begin
        bus.f_req  = ($urandom % 3) != 0;
        bus.f_addr = (32'($urandom_range(0, 15)) << 2) | ((($urandom % 8) == 0) ? 32'h2 : 32'h0);
      end
      if (!bus.ld_req || e_ld_gnt) begin
        bus.ld_req   = ($urandom % 2) != 0;
        bus.ld_we    = ($urandom % 2) != 0;
        bus.ld_lock  = ($urandom % 5) == 0;
        bus.ld_addr  = (32'($urandom_range(0, 15)) << 2) | ((($urandom % 8) == 0) ? 32'h1 : 32'h0);
        bus.ld_wdata = $urandom;
      end
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL random cyc%0d: got %h want %h", n, obs_vec, exp_vec); end
    end
    set_idle();
    repeat (3) begin
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_drain: got %h want %h", obs_vec, exp_vec); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    set_idle(); bus.f_req = 1; bus.f_addr = 32'h30;
    @(negedge clk);
    checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got f_gnt=%b want 1", bus.f_gnt); end
    #1 rst = 1; bus.f_req = 0; bus.f_addr = '0;
    #1;
    checks++;
    if ({bus.f_gnt, bus.ld_gnt, bus.f_rvalid, bus.f_err, bus.ld_rvalid, bus.ld_err, bus.im_we, bus.im_addr} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got gnt=%b/%b rv=%b/%b we=%b addr=%h want all 0",
        bus.f_gnt, bus.ld_gnt, bus.f_rvalid, bus.ld_rvalid, bus.im_we, bus.im_addr);
    end
    repeat (2) begin @(posedge clk); #1 seen |= bus.f_rvalid; end
    @(negedge clk); rst = 0; model_reset();
    @(posedge clk); #1 seen |= bus.f_rvalid;
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_rvalid: got f_rvalid=1 want 0"); end
    bus.f_req = 1; bus.f_addr = 32'h8; bus.ld_req = 1; bus.ld_addr = 32'hC;
    run_cycle();
    checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rstmid_idle_arb: got %h want %h", obs_vec, exp_vec); end
    set_idle();
    repeat (2) begin
      run_cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rstmid_drain: got %h want %h", obs_vec, exp_vec); end
    end
  endtask

  // Main sequence.
  initial begin
    rst = 1;
    set_idle();
    model_reset();
    for (int i = 0; i < 1024; i++) gold[i] = init_word(i);
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_raw();
    test_lock();
    test_misaligned();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
